tpu_cmd_issuer: RTL
===================

// Module: tpu_cmd_issuer
// PURPOSE
//  Host-side initiator for the control unit's command port. Holds a small program buffer of GEMM
//  commands and issues them over the valid/ready interface, packed into 64-bit words. Tracks
//  in-flight commands via done_irq and throttles issue with a credit limit. Pulses all_done once
//  the program has fully retired.
// PARAMETERS
//  ADDR_WIDTH            10  SRAM address width of the addr_a/b/c/d fields
//  SYSTOLIC_ARRAY_WIDTH  16  W; legal len_m/len_k/len_n range is 1..W
//  PROG_DEPTH            16  program buffer entries (power of 2); PW = $clog2(PROG_DEPTH)
//  MAX_OUTSTANDING       4   max issued-but-not-completed commands (1..15)
// PORTS
//  clk               in   1      clock
//  rst               in   1      reset; synchronous, active-high
//  prog_wr_en        in   1      write one program entry
//  prog_wr_addr      in   PW     entry index
//  prog_len_m/k/n    in   8 each command lengths
//  prog_addr_a/b/c/d in   AW each SRAM base addresses
//  start             in   1      launch program entries 0..start_count-1
//  start_count       in   PW+1   number of entries to run
//  abort             in   1      stop issuing, drain, finish
//  cmd_valid         out  1      command valid to control unit
//  cmd_data          out  64     packed command
//  cmd_ready         in   1      control unit can accept
//  done_irq          in   1      1-cycle pulse per retired command
//  issuer_busy       out  1      state != IDLE
//  all_done          out  1      1-cycle completion pulse
//  aborted           out  1      sticky; last run ended by abort
//  issued_count      out  PW+1   handshakes this run
//  completed_count   out  PW+1   done_irq pulses this run
//  outstanding       out  4      in-flight commands
//  err_bad_len       out  1      sticky; a skipped entry had an illegal length
//  err_spurious_done out  1      sticky; done_irq arrived with outstanding==0
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; ptr=0. Program buffer contents are not reset.
//  Pack, LSB first: [7:0]=len_m, [15:8]=len_k, [23:16]=len_n, then addr_a, addr_b, addr_c,
//    addr_d (AW bits each). Bits above 24+4*AW are 0.
//  Program writes are accepted only in IDLE; writes in any other state are ignored.
//  FSM: IDLE -> FETCH -> ISSUE -> FETCH ... -> DRAIN -> DONE -> IDLE.
//  - IDLE: on start, latch n=min(start_count, PROG_DEPTH), ptr=0, clear counters and aborted.
//    Go to FETCH, or to DRAIN if n==0. start is ignored outside IDLE.
//  - FETCH: if ptr==n, go to DRAIN. Otherwise read entry[ptr].
//    - Entry has any len equal to 0 or >W: set err_bad_len, ptr++, stay in FETCH; entry not issued.
//    - Entry is legal: wait until outstanding_next < MAX_OUTSTANDING (a done_irq in the same
//      cycle counts), then register cmd_data and go to ISSUE.
//  - ISSUE: cmd_valid=1. While cmd_ready=0, cmd_valid and cmd_data are held stable.
//    On cmd_valid&&cmd_ready: issued_count++, ptr++, cmd_valid=0 next cycle, go to FETCH.
//  - DRAIN: wait for outstanding==0, then go to DONE.
//  - DONE: all_done=1 for exactly one cycle, then IDLE.
//  Latency: start sampled at cycle T -> cmd_valid high at T+2. Issue rate is at most 1 command
//    per 2 cycles, because FETCH is a bubble.
//  outstanding: +1 on handshake, -1 on done_irq; both in one cycle leaves it unchanged.
//    done_irq at 0 sets err_spurious_done and outstanding stays 0.
//    completed_count increments on every done_irq that arrives while outstanding>0.
//  abort (any non-IDLE state) is latched:
//    - if cmd_valid is high, the pending handshake completes first;
//    - then go to DRAIN and set aborted.
//    abort in IDLE is ignored.
//  Reset mid-run returns to IDLE immediately with cmd_valid=0. In-flight commands are forgotten;
//    the control unit must be reset together with this block.
// TESTING
//  1. Load 3 legal entries, start_count=3, cmd_ready=1 -> 3 handshakes with exact packed words;
//     after 3 done_irq, all_done pulses once, issued=completed=3.
//  2. cmd_ready=0 for 5 cycles during ISSUE -> cmd_valid and cmd_data held stable,
//     issued_count unchanged; the handshake occurs on the first ready cycle.
//  3. MAX_OUTSTANDING=2, 4 entries, no done_irq -> exactly 2 issued, cmd_valid then stays 0;
//     one done_irq -> the 3rd is issued within 2 cycles.
//  4. Entry1 len_k=0, entry2 len_n=17, entries 0 and 3 legal -> only 0 and 3 issued,
//     err_bad_len=1, all_done after 2 done_irq.
//  5. done_irq coincident with a handshake -> outstanding unchanged; done_irq in IDLE ->
//     err_spurious_done=1, outstanding=0.
//  6. start_count=0 -> all_done at T+2 with no cmd_valid. abort after 1st issue of 4 ->
//     no further issue, aborted=1, all_done after 1 done_irq.

Source files
------------

// File: rtl/tpu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// tpu_cmd_issuer : replays a small GEMM program buffer onto the control unit's
//                  command port, with credit-limited issue and retire tracking.
// Revision       : 1.0
// ============================================================================
module tpu_cmd_issuer #(
  parameter int ADDR_WIDTH           = 10,
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int PROG_DEPTH           = 16,
  parameter int MAX_OUTSTANDING      = 4,
  localparam int PW                  = $clog2(PROG_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_wr_en,
  input  logic [PW-1:0]         prog_wr_addr,
  input  logic [7:0]            prog_len_m,
  input  logic [7:0]            prog_len_k,
  input  logic [7:0]            prog_len_n,
  input  logic [ADDR_WIDTH-1:0] prog_addr_a,
  input  logic [ADDR_WIDTH-1:0] prog_addr_b,
  input  logic [ADDR_WIDTH-1:0] prog_addr_c,
  input  logic [ADDR_WIDTH-1:0] prog_addr_d,
  input  logic                  start,
  input  logic [PW:0]           start_count,
  input  logic                  abort,
  output logic                  cmd_valid,
  output logic [63:0]           cmd_data,
  input  logic                  cmd_ready,
  input  logic                  done_irq,
  output logic                  issuer_busy,
  output logic                  all_done,
  output logic                  aborted,
  output logic [PW:0]           issued_count,
  output logic [PW:0]           completed_count,
  output logic [3:0]            outstanding,
  output logic                  err_bad_len,
  output logic                  err_spurious_done
);

  localparam int          PK      = 24 + 4 * ADDR_WIDTH;
  localparam logic [PW:0] DEPTH_N = (PW + 1)'(PROG_DEPTH);
  localparam logic [3:0]  MAX_O   = 4'(MAX_OUTSTANDING);
  localparam logic [8:0]  W_LIM   = 9'(SYSTOLIC_ARRAY_WIDTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [PK-1:0] prog_mem [PROG_DEPTH];

  logic [2:0]    state_q, state_d;
  logic [PW:0]   ptr_q, ptr_d;
  logic [PW:0]   n_q, n_d;
  logic [PK-1:0] cmd_q, cmd_d;
  logic [3:0]    outstanding_q, outstanding_d;
  logic [PW:0]   issued_q, issued_d;
  logic [PW:0]   completed_q, completed_d;
  logic          aborted_q, aborted_d;
  logic          abort_pend_q, abort_pend_d;
  logic          err_bad_len_q, err_bad_len_d;
  logic          err_spur_q, err_spur_d;

  logic [PK-1:0] entry;
  logic          entry_bad;
  logic          handshake;
  logic          done_ok;
  logic          abort_any;
  logic [3:0]    out_after_done;
  logic          room;

  function automatic logic len_bad(input logic [7:0] len);
    return (len == 8'd0) || ({1'b0, len} > W_LIM);
  endfunction

  // Program buffer holds the already-packed word; it is deliberately not reset.
  always_ff @(posedge clk) begin
    if (prog_wr_en && (state_q == ST_IDLE)) begin
      prog_mem[prog_wr_addr] <= {prog_addr_d, prog_addr_c, prog_addr_b, prog_addr_a,
                                 prog_len_n, prog_len_k, prog_len_m};
    end
  end

  assign entry          = prog_mem[ptr_q[PW-1:0]];
  assign entry_bad      = len_bad(entry[7:0]) || len_bad(entry[15:8]) || len_bad(entry[23:16]);
  assign handshake      = (state_q == ST_ISSUE) && cmd_ready;
  assign done_ok        = done_irq && (outstanding_q != 4'd0);
  assign abort_any      = abort_pend_q || abort;
  assign out_after_done = outstanding_q - {3'b000, done_ok};
  assign room           = out_after_done < MAX_O;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      n_q           <= '0;
      cmd_q         <= '0;
      outstanding_q <= '0;
      issued_q      <= '0;
      completed_q   <= '0;
      aborted_q     <= 1'b0;
      abort_pend_q  <= 1'b0;
      err_bad_len_q <= 1'b0;
      err_spur_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      n_q           <= n_d;
      cmd_q         <= cmd_d;
      outstanding_q <= outstanding_d;
      issued_q      <= issued_d;
      completed_q   <= completed_d;
      aborted_q     <= aborted_d;
      abort_pend_q  <= abort_pend_d;
      err_bad_len_q <= err_bad_len_d;
      err_spur_q    <= err_spur_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    n_d           = n_q;
    cmd_d         = cmd_q;
    aborted_d     = aborted_q;
    abort_pend_d  = abort_pend_q;
    err_bad_len_d = err_bad_len_q;
    if ((state_q != ST_IDLE) && abort) begin
      abort_pend_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d          = (start_count > DEPTH_N) ? DEPTH_N : start_count;
          ptr_d        = '0;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = (start_count == '0) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (abort_any) begin
          aborted_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (ptr_q == n_q) begin
          state_d = ST_DRAIN;
        end else if (entry_bad) begin
          err_bad_len_d = 1'b1;
          ptr_d         = ptr_q + 1'b1;
        end else if (room) begin
          cmd_d   = entry;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // An abort never cancels a command already presented on the port.
        if (cmd_ready) begin
          ptr_d = ptr_q + 1'b1;
          if (abort_any) begin
            aborted_d = 1'b1;
            state_d   = ST_DRAIN;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          aborted_d = 1'b1;
        end
        if (outstanding_q == 4'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (abort) begin
          aborted_d = 1'b1;
        end
        abort_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q + {3'b000, handshake} - {3'b000, done_ok};
    issued_d      = issued_q + {{PW{1'b0}}, handshake};
    completed_d   = completed_q + {{PW{1'b0}}, done_ok};
    err_spur_d    = err_spur_q || (done_irq && (outstanding_q == 4'd0));
    if ((state_q == ST_IDLE) && start) begin
      issued_d    = '0;
      completed_d = '0;
    end
  end

  always_comb begin
    cmd_valid   = (state_q == ST_ISSUE);
    issuer_busy = (state_q != ST_IDLE);
    all_done    = (state_q == ST_DONE);
  end

  assign cmd_data          = 64'(cmd_q);
  assign aborted           = aborted_q;
  assign issued_count      = issued_q;
  assign completed_count   = completed_q;
  assign outstanding       = outstanding_q;
  assign err_bad_len       = err_bad_len_q;
  assign err_spurious_done = err_spur_q;

endmodule
`default_nettype wire
